mem_access_unit: RTL

Initiator-side controller for the multicycle CPU's data memory port. Accepts one load/store request at a time from the MEM stage and sequences the memory strobes `RD`, `WR`, `address` and `writeData` into the 64-byte, big-endian, byte-addressed data memory. Returns load data from `dataout`. Byte and halfword stores are performed as read-modify-write.

---
 rtl/mem_access_unit.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Data-memory initiator for the multicycle CPU: loads, stores, sub-word RMW.
// Define MAU_SUBWORD_EN to enable byte/halfword access; otherwise word-only.
module mem_access_unit #(
    parameter int MEM_BYTES = 64
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        RD,
    output logic        WR,
    output logic [31:0] address,
    output logic [31:0] writeData,
    input  logic [31:0] dataout
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_CAPTURE,
        WR_ISSUE,
        DONE
    } state_t;

    state_t      state;
    logic        size_ok;
    logic        misalign;
    logic        range_bad;
    logic        req_bad;
    logic [31:0] load_val;

    always_comb begin
`ifdef MAU_SUBWORD_EN
        size_ok = (size != 2'b11);
`else
        size_ok = (size == 2'b10);
`endif
        misalign  = ((size == 2'b01) && addr[0]) ||
                    ((size == 2'b10) && (addr[1:0] != 2'b00));
        range_bad = (addr > 32'(MEM_BYTES - 1));
        req_bad   = !size_ok || misalign || range_bad;
    end

`ifdef MAU_SUBWORD_EN
    logic        we_q;
    logic        sign_q;
    logic [1:0]  size_q;
    logic [1:0]  off_q;
    logic [15:0] wdata_q;
    logic [4:0]  sh;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] merge;

    // Lane k sits at bits 31-8k..24-8k, so the bit offset is (3-k)*8.
    always_comb begin
        sh       = {~off_q, 3'b000};
        lane_b   = dataout[sh +: 8];
        lane_h   = off_q[1] ? dataout[15:0] : dataout[31:16];
        load_val = dataout;
        merge    = dataout;
        unique case (1'b1)
            (size_q == 2'b00): begin
                load_val      = {{24{sign_q & lane_b[7]}}, lane_b};
                merge[sh +: 8] = wdata_q[7:0];
            end
            (size_q == 2'b01): begin
                load_val = {{16{sign_q & lane_h[15]}}, lane_h};
                if (off_q[1])
                    merge[15:0] = wdata_q;
                else
                    merge[31:16] = wdata_q;
            end
            default: ;
        endcase
    end
`else
    assign load_val = dataout;
`endif

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            RD        <= 1'b0;
            WR        <= 1'b0;
            rdata     <= 32'd0;
            address   <= 32'd0;
            writeData <= 32'd0;
`ifdef MAU_SUBWORD_EN
            we_q      <= 1'b0;
            sign_q    <= 1'b0;
            size_q    <= 2'b00;
            off_q     <= 2'b00;
            wdata_q   <= 16'd0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        busy    <= 1'b1;
                        address <= {addr[31:2], 2'b00};
`ifdef MAU_SUBWORD_EN
                        we_q    <= we;
                        sign_q  <= sign;
                        size_q  <= size;
                        off_q   <= addr[1:0];
                        wdata_q <= wdata[15:0];
`endif
                        if (req_bad) begin
                            state <= DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else if (!we || (size != 2'b10)) begin
                            state <= RD_ISSUE;
                            RD    <= 1'b1;
                        end else begin
                            state     <= WR_ISSUE;
                            WR        <= 1'b1;
                            writeData <= wdata;
                        end
                    end
                end
                RD_ISSUE: begin
                    state <= RD_CAPTURE;
                end
                RD_CAPTURE: begin
                    RD <= 1'b0;
`ifdef MAU_SUBWORD_EN
                    if (we_q) begin
                        state     <= WR_ISSUE;
                        WR        <= 1'b1;
                        writeData <= merge;
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                        rdata <= load_val;
                    end
`else
                    state <= DONE;
                    done  <= 1'b1;
                    rdata <= load_val;
`endif
                end
                WR_ISSUE: begin
                    WR    <= 1'b0;
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    RD    <= 1'b0;
                    WR    <= 1'b0;
                end
            endcase
        end
    end

endmodule
